// File: rtl/coin_tracker_if.sv
`default_nettype none
// ============================================================================
// Module : coin_tracker_if
// Brief  : Coin drawer bus - table read port plus draw handshake.
// Rev    : 1.0  initial release
// ============================================================================
interface coin_tracker_if;
    logic [14:0] address;
    logic [15:0] memQout;
    logic        drawCoin_en;
    logic        drawCoinDone;

    // The drawer drives addresses and done pulses; the tracker answers.
    modport master (
        output address,
        output drawCoinDone,
        input  memQout,
        input  drawCoin_en
    );

    modport slave (
        input  address,
        input  drawCoinDone,
        output memQout,
        output drawCoin_en
    );
endinterface
`default_nettype wire

// File: rtl/coin_tracker.sv
`default_nettype none
// ============================================================================
// Module : coin_tracker
// Brief  : Coin table for two maps, player collision scan, score, drawer port.
//          Optional macro SCORE_BCD_EN selects a two-digit BCD score (sat 99).
// Rev    : 1.0  initial release
// ============================================================================
module coin_tracker #(
    parameter int NUM_COINS = 10,
    parameter int MAP2_BASE = 16,
    parameter int PLAYER_SZ = 4
) (
    input  wire logic        clock,
    input  wire logic        resetn,
    input  wire logic        map,
    input  wire logic        load_en,
    input  wire logic [4:0]  load_addr,
    input  wire logic [14:0] load_xy,
    input  wire logic        check_en,
    input  wire logic [7:0]  player_x,
    input  wire logic [6:0]  player_y,
    coin_tracker_if.slave    drawer,
    output logic             check_done,
    output logic [7:0]       score,
    output logic             all_collected
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_SCAN      = 2'd1;
    localparam logic [1:0] c_DRAW      = 2'd2;
    localparam logic [3:0] c_LAST_IDX  = 4'(NUM_COINS - 1);
    localparam logic [4:0] c_LAST_DONE = 5'(NUM_COINS - 1);
    localparam logic [4:0] c_MAP2_BASE = 5'(MAP2_BASE);
    localparam logic [8:0] c_PSZ_X     = 9'(PLAYER_SZ - 1);
    localparam logic [7:0] c_PSZ_Y     = 8'(PLAYER_SZ - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_exist;
    logic [7:0]  r_x [32];
    logic [6:0]  r_y [32];
    logic        r_map;
    logic [7:0]  r_px;
    logic [6:0]  r_py;
    logic [3:0]  r_idx;
    logic [4:0]  r_done_cnt;
    logic [7:0]  r_score;
    logic [15:0] r_memq;

    logic [4:0]  w_scan_addr;
    logic [7:0]  w_cx;
    logic [6:0]  w_cy;
    logic        w_ovl_x;
    logic        w_ovl_y;
    logic        w_hit;
    logic        w_load;
    logic        w_start;
    logic        w_scan_last;
    logic        w_draw_last;
    logic [7:0]  w_score_inc;
    logic [4:0]  w_live_base;
    logic [4:0]  w_rd_addr;

    assign w_scan_addr = (r_map ? c_MAP2_BASE : 5'd0) + {1'b0, r_idx};
    assign w_cx        = r_x[w_scan_addr];
    assign w_cy        = r_y[w_scan_addr];

    // Coin is 2x2 and the player is PLAYER_SZ square; widened so x+1 never wraps.
    assign w_ovl_x = ({1'b0, r_px} <= ({1'b0, w_cx} + 9'd1)) &&
                     ({1'b0, w_cx} <= ({1'b0, r_px} + c_PSZ_X));
    assign w_ovl_y = ({1'b0, r_py} <= ({1'b0, w_cy} + 8'd1)) &&
                     ({1'b0, w_cy} <= ({1'b0, r_py} + c_PSZ_Y));

    assign w_hit       = (r_state == c_SCAN) && r_exist[w_scan_addr] && w_ovl_x && w_ovl_y;
    assign w_load      = (r_state == c_IDLE) && load_en;
    assign w_start     = (r_state == c_IDLE) && check_en;
    assign w_scan_last = (r_state == c_SCAN) && (r_idx == c_LAST_IDX);
    assign w_draw_last = (r_state == c_DRAW) && drawer.drawCoinDone &&
                         (r_done_cnt == c_LAST_DONE);

`ifdef SCORE_BCD_EN
    always_comb begin
        w_score_inc = r_score;
        if (r_score == 8'h99)
            w_score_inc = r_score;
        else if (r_score[3:0] == 4'd9)
            w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
        else
            w_score_inc = r_score + 8'd1;
    end
`else
    always_comb begin
        w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    end
`endif

    always_ff @(posedge clock) begin
        if (!resetn)
            r_state <= c_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (check_en)    w_next_state = c_SCAN;
            c_SCAN:  if (w_scan_last) w_next_state = c_DRAW;
            c_DRAW:  if (w_draw_last) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        check_done         = 1'b0;
        drawer.drawCoin_en = 1'b0;
        case (r_state)
            c_SCAN:  check_done         = (r_idx == c_LAST_IDX);
            c_DRAW:  drawer.drawCoin_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_exist <= '0;
            for (int i = 0; i < 32; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_exist[load_addr] <= 1'b1;
                r_x[load_addr]     <= load_xy[14:7];
                r_y[load_addr]     <= load_xy[6:0];
            end
            if (w_hit)
                r_exist[w_scan_addr] <= 1'b0;
        end
    end

    // Registered read sees the table before any same-cycle clear.
    assign w_rd_addr = drawer.address[4:0];
    always_ff @(posedge clock) begin
        if (!resetn)
            r_memq <= '0;
        else if (|drawer.address[14:5])
            r_memq <= '0;
        else
            r_memq <= {r_exist[w_rd_addr], r_x[w_rd_addr], r_y[w_rd_addr]};
    end
    assign drawer.memQout = r_memq;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_map      <= 1'b0;
            r_px       <= '0;
            r_py       <= '0;
            r_idx      <= '0;
            r_done_cnt <= '0;
            r_score    <= '0;
        end else begin
            if (w_start) begin
                r_map <= map;
                r_px  <= player_x;
                r_py  <= player_y;
                r_idx <= '0;
            end
            if (r_state == c_SCAN)
                r_idx <= r_idx + 4'd1;
            if (w_hit)
                r_score <= w_score_inc;
            if (w_scan_last)
                r_done_cnt <= '0;
            else if ((r_state == c_DRAW) && drawer.drawCoinDone)
                r_done_cnt <= r_done_cnt + 5'd1;
        end
    end
    assign score = r_score;

    // Follows the live map input, not the map latched for the last scan.
    assign w_live_base = map ? c_MAP2_BASE : 5'd0;
    always_comb begin
        all_collected = 1'b1;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (r_exist[w_live_base + 5'(i)])
                all_collected = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coin_tracker.sv
`default_nettype none
// ============================================================================
// Module : tb_coin_tracker
// Brief  : Scoreboard bench for coin_tracker (loads, scans, draw handshake).
// Rev    : 1.0  initial release
// ============================================================================
module tb_coin_tracker;
    localparam int NC = 10;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        map = 1'b0;
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [14:0] load_xy = '0;
    logic        check_en = 1'b0;
    logic [7:0]  player_x = '0;
    logic [6:0]  player_y = '0;
    logic        check_done;
    logic [7:0]  score;
    logic        all_collected;

    coin_tracker_if bus ();

    coin_tracker dut (
        .clock         (clock),
        .resetn        (resetn),
        .map           (map),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_xy       (load_xy),
        .check_en      (check_en),
        .player_x      (player_x),
        .player_y      (player_y),
        .drawer        (bus.slave),
        .check_done    (check_done),
        .score         (score),
        .all_collected (all_collected)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [7:0]  exp_score = '0;
    logic [15:0] rd_q[$];
    logic [7:0]  sc_q[$];
    logic        rd_req = 1'b0;
    logic        rd_valid = 1'b0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rd_valid <= rd_req;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] inc(input logic [7:0] s);
`ifdef SCORE_BCD_EN
        if (s == 8'h99) return s;
        if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
        return s + 8'd1;
`else
        return (s == 8'hFF) ? s : s + 8'd1;
`endif
    endfunction

    // Monitor: pops expectations whenever the DUT presents read data or ends a scan.
    initial begin
        bit seen = 0;
        forever begin
            @(negedge clock);
            if (rd_valid) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 16'd1, 16'd0);
                else chk("memQout", bus.memQout, rd_q.pop_front());
            end
            if (seen) begin
                seen = 0;
                chk("check_done_width", {15'd0, check_done}, 16'd0);
                chk("drawCoin_en_rise", {15'd0, bus.drawCoin_en}, 16'd1);
                if (sc_q.size() == 0) chk("score_unexpected", 16'd1, 16'd0);
                else chk("score", {8'd0, score}, {8'd0, sc_q.pop_front()});
            end
            if (check_done) seen = 1;
        end
    end

    task automatic rd(input logic [14:0] a, input logic [15:0] exp);
        @(negedge clock);
        bus.address = a;
        rd_req = 1'b1;
        rd_q.push_back(exp);
        @(negedge clock);
        rd_req = 1'b0;
    endtask

    task automatic load(input logic [4:0] a, input logic [7:0] x, input logic [6:0] y);
        @(negedge clock);
        load_en   = 1'b1;
        load_addr = a;
        load_xy   = {x, y};
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic do_check(input logic [7:0] px, input logic [6:0] py, input int hits,
                            input logic mp, input bit inj_chk, input bit inj_load);
        int t0;
        int t;
        @(negedge clock);
        map = mp;
        player_x = px;
        player_y = py;
        check_en = 1'b1;
        t0 = cyc;
        for (int h = 0; h < hits; h++) exp_score = inc(exp_score);
        sc_q.push_back(exp_score);
        @(negedge clock);
        check_en = 1'b0;
        if (inj_chk) begin
            @(negedge clock);
            @(negedge clock);
            player_x = 8'd100;
            player_y = 7'd100;
            check_en = 1'b1;
            @(negedge clock);
            check_en = 1'b0;
        end
        t = 0;
        while (!bus.drawCoin_en && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!bus.drawCoin_en) begin
            chk("draw_timeout", 16'd1, 16'd0);
            return;
        end
        chk("scan_latency", 16'(cyc - t0), 16'(NC + 1));
        for (int i = 0; i < NC; i++) begin
            bus.drawCoinDone = 1'b1;
            if (inj_load && i == 3) begin
                load_en   = 1'b1;
                load_addr = 5'd2;
                load_xy   = {8'd5, 7'd5};
            end
            @(negedge clock);
            bus.drawCoinDone = 1'b0;
            load_en = 1'b0;
            if (i == NC - 2) chk("draw_en_after_9", {15'd0, bus.drawCoin_en}, 16'd1);
            if (i == NC - 1) chk("draw_en_after_10", {15'd0, bus.drawCoin_en}, 16'd0);
            @(negedge clock);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address      = '0;
        bus.drawCoinDone = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_memQout", bus.memQout, 16'd0);
        chk("rst_draw_en", {15'd0, bus.drawCoin_en}, 16'd0);
        chk("rst_check_done", {15'd0, check_done}, 16'd0);
        chk("rst_score", {8'd0, score}, 16'd0);
        chk("rst_all_collected", {15'd0, all_collected}, 16'd1);
        resetn = 1'b1;

        // Single coin hit, then a full draw handshake.
        load(5'd0, 8'd20, 7'd30);
        chk("ac_after_load", {15'd0, all_collected}, 16'd0);
        do_check(8'd18, 7'd28, 1, 1'b0, 0, 0);
        rd(15'd0, {1'b0, 8'd20, 7'd30});

        // Misses and the edge cases around the coin's right/bottom pixel.
        load(5'd0, 8'd20, 7'd30);
        do_check(8'd10, 7'd10, 0, 1'b0, 0, 0);
        do_check(8'd22, 7'd30, 0, 1'b0, 0, 0);
        rd(15'd0, {1'b1, 8'd20, 7'd30});
        do_check(8'd21, 7'd31, 1, 1'b0, 0, 0);
        rd(15'd0, {1'b0, 8'd20, 7'd30});

        // MAP2 collection and map-dependent all_collected.
        load(5'd1, 8'd100, 7'd100);
        for (int i = 0; i < NC; i++) load(5'(16 + i), 8'd50, 7'd60);
        do_check(8'd50, 7'd60, NC, 1'b1, 0, 0);
        @(negedge clock);
        chk("ac_map2", {15'd0, all_collected}, 16'd1);
        map = 1'b0;
        #1;
        chk("ac_map1", {15'd0, all_collected}, 16'd0);
        rd(15'd16, {1'b0, 8'd50, 7'd60});
        rd(15'd33, 16'd0);
        rd(15'd1, {1'b1, 8'd100, 7'd100});

        // check_en in SCAN and load_en in DRAW are ignored.
        do_check(8'd0, 7'd0, 0, 1'b0, 1, 1);
        rd(15'd2, 16'd0);
        rd(15'd1, {1'b1, 8'd100, 7'd100});

        // Reset in the middle of a scan that has already scored.
        @(negedge clock);
        player_x = 8'd100;
        player_y = 7'd100;
        check_en = 1'b1;
        @(negedge clock);
        check_en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        exp_score = '0;
        chk("midscan_rst_score", {8'd0, score}, 16'd0);
        chk("midscan_rst_draw_en", {15'd0, bus.drawCoin_en}, 16'd0);
        chk("midscan_rst_check_done", {15'd0, check_done}, 16'd0);
        rd(15'd1, 16'd0);
        rd(15'd16, 16'd0);
        chk("midscan_rst_ac", {15'd0, all_collected}, 16'd1);

        // Nine hits then one more: 09 -> 10 carry (BCD) or 9 -> 10 (binary).
        for (int i = 0; i < 9; i++) load(5'(i), 8'd20, 7'd30);
        do_check(8'd18, 7'd28, 9, 1'b0, 0, 0);
        load(5'd0, 8'd20, 7'd30);
        do_check(8'd18, 7'd28, 1, 1'b0, 0, 0);
`ifdef SCORE_BCD_EN
        chk("bcd_carry", {8'd0, score}, 16'h0010);
`else
        chk("bin_ten", {8'd0, score}, 16'h000A);
`endif

        // Drive the score well past saturation.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NC; i++) load(5'(i), 8'd20, 7'd30);
            do_check(8'd18, 7'd28, NC, 1'b0, 0, 0);
        end
`ifdef SCORE_BCD_EN
        chk("score_saturated", {8'd0, score}, 16'h0099);
`else
        chk("score_saturated", {8'd0, score}, 16'h00FF);
`endif

        repeat (3) @(negedge clock);
        chk("sb_drain", 16'(rd_q.size() + sc_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
